// File: rtl/bounce_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bounce_count_ctrl
// Brief    : Two-requester round-robin arbiter owning a shared 0->LIM->0
//            bounce counter that runs NP round trips per granted job.
// Revision : 1.0 - initial release
// ============================================================================
module bounce_count_ctrl #(
    parameter int W   = 4,
    parameter int NPW = 4
) (
    input  logic           CLK,
    input  logic           R,
    input  logic [1:0]     REQ,
    input  logic [W-1:0]   LIM0,
    input  logic [W-1:0]   LIM1,
    input  logic [NPW-1:0] NP0,
    input  logic [NPW-1:0] NP1,
    input  logic           ABT,
    output logic [1:0]     GNT,
    output logic           BUSY,
    output logic [W-1:0]   O,
    output logic           DIR,
    output logic [1:0]     DONE
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UP     = 2'd1,
        S_DOWN   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_o;
    logic           r_dir;
    logic [1:0]     r_gnt;
    logic           r_busy;
    logic [1:0]     r_done;
    logic           r_pri;
    logic           r_gidx;
    logic [W-1:0]   r_lim;
    logic [NPW-1:0] r_rem;

    logic           w_gidx;
    logic [1:0]     w_gnt_onehot;
    logic [W-1:0]   w_lim_sel;
    logic [NPW-1:0] w_np_sel;
    logic [W-1:0]   w_o_inc;
    logic [W-1:0]   w_o_dec;

    // Pointer requester wins if requesting, otherwise the other one.
    always_comb begin
        w_gidx       = REQ[r_pri] ? r_pri : ~r_pri;
        w_gnt_onehot = w_gidx ? 2'b10 : 2'b01;
        w_lim_sel    = w_gidx ? LIM1 : LIM0;
        w_np_sel     = w_gidx ? NP1 : NP0;
        w_o_inc      = r_o + W'(1);
        w_o_dec      = r_o - W'(1);
    end

    always_ff @(posedge CLK) begin
        if (R) begin
            r_state <= S_IDLE;
            r_o     <= '0;
            r_dir   <= 1'b0;
            r_gnt   <= 2'b00;
            r_busy  <= 1'b0;
            r_done  <= 2'b00;
            r_pri   <= 1'b0;
            r_gidx  <= 1'b0;
            r_lim   <= '0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_o    <= '0;
                    r_dir  <= 1'b0;
                    r_done <= 2'b00;
                    if (|REQ) begin
                        r_gidx <= w_gidx;
                        r_gnt  <= w_gnt_onehot;
                        r_busy <= 1'b1;
                        r_lim  <= w_lim_sel;
                        r_rem  <= w_np_sel;
                        if ((w_lim_sel == '0) || (w_np_sel == '0)) begin
                            r_state <= S_FINISH;
                            r_done  <= w_gnt_onehot;
                        end else begin
                            r_state <= S_UP;
                        end
                    end
                end
                S_UP: begin
                    if (ABT) begin
                        r_state <= S_FINISH;
                        r_o     <= '0;
                        r_dir   <= 1'b0;
                        r_done  <= r_gnt;
                    end else begin
                        r_o <= w_o_inc;
                        if (w_o_inc == r_lim) begin
                            r_state <= S_DOWN;
                            r_dir   <= 1'b1;
                        end
                    end
                end
                S_DOWN: begin
                    if (ABT) begin
                        r_state <= S_FINISH;
                        r_o     <= '0;
                        r_dir   <= 1'b0;
                        r_done  <= r_gnt;
                    end else begin
                        r_o <= w_o_dec;
                        if (w_o_dec == '0) begin
                            r_rem <= r_rem - NPW'(1);
                            r_dir <= 1'b0;
                            if (r_rem == NPW'(1)) begin
                                r_state <= S_FINISH;
                                r_done  <= r_gnt;
                            end else begin
                                r_state <= S_UP;
                            end
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_pri   <= ~r_gidx;
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                    r_done  <= 2'b00;
                    r_o     <= '0;
                    r_dir   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign GNT  = r_gnt;
    assign BUSY = r_busy;
    assign O    = r_o;
    assign DIR  = r_dir;
    assign DONE = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bounce_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bounce_count_ctrl
// Brief    : Directed self-checking bench for bounce_count_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bounce_count_ctrl;

    localparam int W   = 4;
    localparam int NPW = 4;

    logic           CLK = 1'b0;
    logic           R   = 1'b1;
    logic [1:0]     REQ = 2'b00;
    logic [W-1:0]   LIM0 = '0;
    logic [W-1:0]   LIM1 = '0;
    logic [NPW-1:0] NP0 = '0;
    logic [NPW-1:0] NP1 = '0;
    logic           ABT = 1'b0;
    logic [1:0]     GNT;
    logic           BUSY;
    logic [W-1:0]   O;
    logic           DIR;
    logic [1:0]     DONE;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    bounce_count_ctrl #(.W(W), .NPW(NPW)) dut (
        .CLK (CLK),  .R (R),      .REQ (REQ),
        .LIM0(LIM0), .LIM1(LIM1), .NP0 (NP0), .NP1(NP1),
        .ABT (ABT),  .GNT (GNT),  .BUSY(BUSY),
        .O   (O),    .DIR (DIR),  .DONE(DONE)
    );

    task automatic do_reset();
        @(negedge CLK);
        R = 1'b1; REQ = 2'b00; ABT = 1'b0;
        @(negedge CLK);
        R = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        R = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if ({GNT, BUSY, O, DIR, DONE} !== '0) begin
            errors++;
            $display("FAIL reset_state: gnt=%b busy=%b o=%0d dir=%b done=%b, required all 0",
                     GNT, BUSY, O, DIR, DONE);
        end
        R = 1'b0;
    endtask

    task automatic test_single();
        logic [W-1:0] exp_o    [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0};
        logic         exp_dir  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0]   exp_done [7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        do_reset();
        REQ = 2'b01; LIM0 = 4'd3; NP0 = 4'd1;
        for (int k = 0; k < 7; k++) begin
            @(negedge CLK);
            if (k == 0) begin
                // Changes after the grant edge must not disturb the job.
                REQ = 2'b10; LIM0 = 4'd7; NP0 = 4'd5;
            end
            checks++;
            if (O !== exp_o[k] || DIR !== exp_dir[k] || DONE !== exp_done[k] ||
                BUSY !== 1'b1 || GNT !== 2'b01) begin
                errors++;
                $display("FAIL single_step%0d: o=%0d dir=%b done=%b busy=%b gnt=%b, required o=%0d dir=%b done=%b busy=1 gnt=01",
                         k, O, DIR, DONE, BUSY, GNT, exp_o[k], exp_dir[k], exp_done[k]);
            end
        end
        @(negedge CLK);
        REQ = 2'b00;
        checks++;
        if (BUSY !== 1'b0 || GNT !== 2'b00 || DONE !== 2'b00) begin
            errors++;
            $display("FAIL single_idle: busy=%b gnt=%b done=%b, required 0/00/00", BUSY, GNT, DONE);
        end
    endtask

    task automatic test_alternate();
        logic [1:0] exp_gnt;
        do_reset();
        REQ = 2'b11; LIM0 = 4'd2; LIM1 = 4'd2; NP0 = 4'd1; NP1 = 4'd1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge CLK);
            if (k <= 5)       exp_gnt = 2'b01;
            else if (k == 6)  exp_gnt = 2'b00;
            else if (k <= 11) exp_gnt = 2'b10;
            else if (k == 12) exp_gnt = 2'b00;
            else              exp_gnt = 2'b01;
            checks++;
            if (GNT !== exp_gnt) begin
                errors++;
                $display("FAIL alt_gnt_cycle%0d: gnt=%b, required %b", k, GNT, exp_gnt);
            end
            if (k == 5 || k == 11) begin
                checks++;
                if (DONE !== exp_gnt) begin
                    errors++;
                    $display("FAIL alt_done_cycle%0d: done=%b, required %b", k, DONE, exp_gnt);
                end
            end
        end
        REQ = 2'b00;
    endtask

    task automatic test_max();
        int busy_cnt = 0;
        int peaks    = 0;
        int wraps    = 0;
        logic [W-1:0] prev_o = '0;
        do_reset();
        REQ = 2'b01; LIM0 = 4'd15; NP0 = 4'd2;
        @(negedge CLK);
        REQ = 2'b00;
        while (BUSY === 1'b1 && busy_cnt < 200) begin
            busy_cnt++;
            if (O == 4'd15) peaks++;
            if (prev_o == 4'd15 && O == 4'd0) wraps++;
            prev_o = O;
            @(negedge CLK);
        end
        checks++;
        if (busy_cnt != 61) begin
            errors++;
            $display("FAIL max_busy_len: busy cycles=%0d, required 61", busy_cnt);
        end
        checks++;
        if (peaks != 2 || wraps != 0) begin
            errors++;
            $display("FAIL max_peaks: peaks=%0d wraps=%0d, required 2 and 0", peaks, wraps);
        end
    endtask

    task automatic test_zero();
        for (int z = 0; z < 2; z++) begin
            @(negedge CLK);
            REQ = 2'b10;
            LIM1 = (z == 0) ? 4'd0 : 4'd5;
            NP1  = (z == 0) ? 4'd3 : 4'd0;
            @(negedge CLK);
            REQ = 2'b00;
            checks++;
            if (BUSY !== 1'b1 || GNT !== 2'b10 || DONE !== 2'b10 || O !== 4'd0) begin
                errors++;
                $display("FAIL zero_job%0d: busy=%b gnt=%b done=%b o=%0d, required 1/10/10/0",
                         z, BUSY, GNT, DONE, O);
            end
            @(negedge CLK);
            checks++;
            if (BUSY !== 1'b0 || DONE !== 2'b00 || O !== 4'd0) begin
                errors++;
                $display("FAIL zero_end%0d: busy=%b done=%b o=%0d, required 0/00/0", z, BUSY, DONE, O);
            end
        end
    endtask

    task automatic test_abort();
        do_reset();
        REQ = 2'b01; LIM0 = 4'd5; NP0 = 4'd1;
        @(negedge CLK);
        REQ = 2'b00;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (O !== 4'd2 || DIR !== 1'b0) begin
            errors++;
            $display("FAIL abort_pre: o=%0d dir=%b, required 2/0", O, DIR);
        end
        ABT = 1'b1;
        @(negedge CLK);
        ABT = 1'b0;
        checks++;
        if (O !== 4'd0 || DIR !== 1'b0 || DONE !== 2'b01 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL abort_finish: o=%0d dir=%b done=%b busy=%b, required 0/0/01/1",
                     O, DIR, DONE, BUSY);
        end
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || GNT !== 2'b00 || DONE !== 2'b00) begin
            errors++;
            $display("FAIL abort_idle: busy=%b gnt=%b done=%b, required 0/00/00", BUSY, GNT, DONE);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] done_seen = 2'b00;
        do_reset();
        REQ = 2'b01; LIM0 = 4'd5; NP0 = 4'd1;
        for (int k = 0; k < 7; k++) begin
            @(negedge CLK);
            REQ = 2'b00;
        end
        checks++;
        if (O !== 4'd4 || DIR !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: o=%0d dir=%b, required 4/1", O, DIR);
        end
        R = 1'b1;
        @(negedge CLK);
        done_seen = DONE;
        checks++;
        if ({GNT, BUSY, O, DIR, DONE} !== '0) begin
            errors++;
            $display("FAIL rstmid_clear: gnt=%b busy=%b o=%0d dir=%b done=%b, required all 0",
                     GNT, BUSY, O, DIR, DONE);
        end
        R = 1'b0; REQ = 2'b11; LIM0 = 4'd1; LIM1 = 4'd1;
        @(negedge CLK);
        done_seen |= DONE;
        REQ = 2'b00;
        checks++;
        if (GNT !== 2'b01 || done_seen !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_pri: gnt=%b done_seen=%b, required 01/00", GNT, done_seen);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_max();
        test_zero();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
